// File: rtl/data_mem_ctrl.sv
// Handshaked load/store data memory with RISC-V byte/half/word access, configurable latency
// and a single outstanding request; faulting accesses never touch the RAM.
module data_mem_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    LATENCY     = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_func3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_r, state_nx;
    logic [CNT_W-1:0]      cnt_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic [2:0]            func3_r;
    logic [31:0]           mem [DEPTH_WORDS];

    logic                  accept_s, commit_s, fault_s;
    logic [ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      idx_s;
    logic [31:0]           word_s, load_s, wval_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;
    logic [3:0]            wmask_s;
    logic                  range_flt_s, align_flt_s, func_flt_s;

    assign req_ready = (state_r == IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    assign commit_s  = (state_r == WAIT) && (cnt_r == '0);

    // Decode the latched request: fault checks, load extraction and store lane mask.
    always_comb begin
        offset_s    = addr_r - BASE_ADDR;
        range_flt_s = {1'b0, offset_s} >= SPAN;
        align_flt_s = ((func3_r[1:0] == 2'd1) && offset_s[0]) ||
                      ((func3_r[1:0] == 2'd2) && (offset_s[1:0] != 2'd0));
        if (we_r) begin
            func_flt_s = func3_r > 3'd2;
        end else begin
            func_flt_s = !(func3_r inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        fault_s = range_flt_s || align_flt_s || func_flt_s;
        idx_s   = offset_s[IDX_W+1:2];
        word_s  = mem[idx_s];
        byte_s  = word_s[{offset_s[1:0], 3'b000} +: 8];
        half_s  = offset_s[1] ? word_s[31:16] : word_s[15:0];
        case (func3_r)
            3'd0:    load_s = {{24{byte_s[7]}}, byte_s};
            3'd1:    load_s = {{16{half_s[15]}}, half_s};
            3'd2:    load_s = word_s;
            3'd4:    load_s = {24'd0, byte_s};
            3'd5:    load_s = {16'd0, half_s};
            default: load_s = 32'd0;
        endcase
        case (func3_r[1:0])
            2'd0: begin
                wmask_s = 4'b0001 << offset_s[1:0];
                wval_s  = {4{wdata_r[7:0]}};
            end
            2'd1: begin
                wmask_s = offset_s[1] ? 4'b1100 : 4'b0011;
                wval_s  = {2{wdata_r[15:0]}};
            end
            2'd2: begin
                wmask_s = 4'b1111;
                wval_s  = wdata_r;
            end
            default: begin
                wmask_s = 4'b0000;
                wval_s  = 32'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx = WAIT;
                else          state_nx = IDLE;
            end
            WAIT: begin
                if (cnt_r == '0) state_nx = RESP;
                else             state_nx = WAIT;
            end
            RESP: begin
                if (resp_valid && resp_ready) state_nx = IDLE;
                else                          state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, latency counter and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            func3_r    <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                func3_r <= req_func3;
                cnt_r   <= CNT_INIT;
            end else if ((state_r == WAIT) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (commit_s) begin
                resp_valid <= 1'b1;
                resp_fault <= fault_s;
                resp_rdata <= (fault_s || we_r) ? 32'd0 : load_s;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                resp_fault <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    // RAM byte-lane write on the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s && we_r && !fault_s && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) mem[idx_s][8*b +: 8] <= wval_s[8*b +: 8];
            end
        end
    end

endmodule
